// File: rtl/rca_accum_ctrl.sv
`timescale 1ns/1ps
// rca_accum_ctrl
//
// Accumulation controller wrapped around an external combinational 4-bit
// ripple-carry adder. A run of up to seven unsigned 4-bit operands is summed
// into a 7-bit result. The adder produces the low nibble. The upper three bits
// come from counting the adder's carry-outs.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and its data stable until that
// edge. Here in_ready and out_valid are pure state decodes, so they never
// depend combinationally on the opposite side's valid/ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a run (sampled only in IDLE)
//   count[2:0] operands in the run, sampled with start (0 gives result 0)
//   abort      synchronous cancel, back to IDLE with no result
//   in_valid / in_data[3:0] / in_ready    operand port
//   add_a[3:0], add_b[3:0], add_cin       drive the external adder
//   add_s[3:0], add_cout                  external adder result
//   out_valid / out_sum[6:0] / out_ready  result port
//   dbg_state[1:0]                        FSM state: 0 IDLE, 1 ACCUM, 2 DONE
module rca_accum_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] count,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  input  logic [3:0] add_s,
  input  logic       add_cout,
  output logic       out_valid,
  output logic [6:0] out_sum,
  input  logic       out_ready,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] acc_lo;
  logic [2:0] acc_hi;
  logic [2:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_lo    <= 4'd0;
      acc_hi    <= 3'd0;
      remaining <= 3'd0;
    end else if (abort) begin
      // Abort wins over start, beat acceptance and the result handshake.
      // The accumulator keeps its value. Only the run bookkeeping is dropped.
      state     <= IDLE;
      remaining <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_lo <= 4'd0;
            acc_hi <= 3'd0;
            if (count != 3'd0) begin
              remaining <= count;
              state     <= ACCUM;
            end else begin
              // An empty run goes straight to DONE with a zero result.
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          // in_ready is high throughout ACCUM, so in_valid alone marks a beat.
          if (in_valid) begin
            acc_lo    <= add_s;
            acc_hi    <= acc_hi + {2'b00, add_cout};
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The adder is fed in every state. Its result is only consumed on a beat.
  assign add_a   = acc_lo;
  assign add_b   = in_data;
  assign add_cin = 1'b0;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_sum   = {acc_hi, acc_lo};
  assign dbg_state = state;

endmodule

// File: tb/tb_rca_accum_ctrl.sv
`timescale 1ns/1ps
module tb_rca_accum_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start;
  logic [2:0] count;
  logic       abort;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;
  logic       out_valid;
  logic [6:0] out_sum;
  logic       out_ready;
  logic [1:0] dbg_state;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Behavioural stand-in for the external 4-bit ripple-carry adder.
  logic [4:0] adder_full;
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};
  assign add_s      = adder_full[3:0];
  assign add_cout   = adder_full[4];

  rca_accum_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Each step ends 1 ns after a rising edge: outputs are sampled there and
  // the next inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [2:0] c);
    start = 1'b1;
    count = c;
    tick();
    start = 1'b0;
    count = 3'd0;
  endtask

  task automatic beat(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  int beats;
  logic ready_seen;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    count     = 3'd0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_add_a",     add_a,     0);
    check("rst_add_cin",   add_cin,   0);
    check("rst_state",     dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();
    check("idle_state", dbg_state, ST_IDLE);

    // ---- basic run with carry: 5 + 7 + 9 = 21 ----
    run_start(3'd3);
    check("basic_in_ready", in_ready, 1);
    check("basic_state_accum", dbg_state, ST_ACCUM);
    in_valid = 1'b1;
    in_data  = 4'd5;
    #1;
    check("basic_add_b", add_b, 5);
    tick();
    check("basic_add_a_after5", add_a, 5);
    in_data = 4'd7;
    tick();
    check("basic_add_a_after12", add_a, 12);
    check("basic_no_valid_early", out_valid, 0);
    in_data = 4'd9;
    tick();
    in_valid = 1'b0;
    check("basic_out_valid", out_valid, 1);
    check("basic_out_sum", out_sum, 21);
    check("basic_in_ready_done", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("basic_back_idle", dbg_state, ST_IDLE);
    check("basic_valid_dropped", out_valid, 0);
    check("basic_sum_held", out_sum, 21);

    // ---- result backpressure, start in DONE ignored ----
    run_start(3'd3);
    beat(4'd5);
    beat(4'd7);
    beat(4'd9);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1;
        count = 3'd2;
      end else begin
        start = 1'b0;
        count = 3'd0;
      end
      check("bp_out_valid", out_valid, 1);
      check("bp_out_sum", out_sum, 21);
      tick();
    end
    start = 1'b0;
    check("bp_still_done", dbg_state, ST_DONE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_after_hs", dbg_state, ST_IDLE);
    tick();
    check("bp_start_ignored", dbg_state, ST_IDLE);

    // ---- maximum sum with random in_valid gaps ----
    run_start(3'd7);
    beats = 0;
    for (int i = 0; i < 80 && beats < 7; i++) begin
      in_valid   = (i >= 40) ? 1'b1 : 1'(($urandom_range(0, 2) != 0));
      in_data    = 4'd15;
      ready_seen = in_ready;
      tick();
      if (in_valid && ready_seen) beats++;
    end
    check("max_beats_done", beats, 7);
    // Keep offering operands: none may be accepted after the seventh.
    in_valid = 1'b1;
    in_data  = 4'd15;
    for (int i = 0; i < 3; i++) begin
      check("max_in_ready_low", in_ready, 0);
      check("max_out_sum", out_sum, 105);
      tick();
    end
    in_valid = 1'b0;
    check("max_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ---- count = 0 ----
    run_start(3'd0);
    check("zero_out_valid", out_valid, 1);
    check("zero_out_sum", out_sum, 0);
    check("zero_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("zero_idle", dbg_state, ST_IDLE);
    check("zero_in_ready_after", in_ready, 0);

    // ---- abort in the same cycle as a valid beat ----
    run_start(3'd4);
    beat(4'd8);
    beat(4'd8);
    check("abort_partial", out_sum, 16);
    in_valid = 1'b1;
    in_data  = 4'd8;
    abort    = 1'b1;
    check("abort_ready_before", in_ready, 1);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_idle", dbg_state, ST_IDLE);
    check("abort_beat_dropped", out_sum, 16);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_valid", out_valid, 0);
      tick();
    end
    run_start(3'd2);
    beat(4'd1);
    beat(4'd2);
    check("abort_follow_valid", out_valid, 1);
    check("abort_follow_sum", out_sum, 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ---- asynchronous reset mid-run ----
    run_start(3'd4);
    beat(4'd3);
    beat(4'd4);
    check("rstmid_partial", out_sum, 7);
    in_valid = 1'b1;
    in_data  = 4'd6;
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_state", dbg_state, ST_IDLE);
    check("rstmid_in_ready", in_ready, 0);
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_sum", out_sum, 0);
    check("rstmid_add_a", add_a, 0);
    in_valid = 1'b0;
    in_data  = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();
    run_start(3'd1);
    beat(4'd9);
    check("rstmid_follow_valid", out_valid, 1);
    check("rstmid_follow_sum", out_sum, 9);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rstmid_follow_idle", dbg_state, ST_IDLE);

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_accum_ctrl.md
# rca_accum_ctrl

Sequential accumulation controller wrapped around the combinational 4-bit ripple-carry adder. It accepts a run of 4-bit operands over a valid/ready handshake and drives the adder's A/B/Cin inputs each beat. It consumes the adder's S/Cout outputs and builds a 7-bit running sum, using a carry-count extension for the upper bits. The final sum is presented on a valid/ready result port; the block sits between an operand source and the result sink.

## Interface
- Parameters: none; operand width fixed at 4, sum width fixed at 7, max run length 7.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- count  input  3  number of operands in the run, sampled with start (0..7).
- abort  input  1  synchronous cancel; returns to IDLE with no result.
- in_valid  input  1  operand available.
- in_data  input  4  operand value (unsigned).
- in_ready  output  1  block can accept an operand this cycle.
- add_a  output  4  adder operand A = acc_lo.
- add_b  output  4  adder operand B = in_data.
- add_cin  output  1  adder carry-in, constant 0.
- add_s  input  4  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result available.
- out_sum  output  7  result {acc_hi[2:0], acc_lo[3:0]}.
- out_ready  input  1  sink accepts the result.

## Operation
- Registers:
  - state: IDLE, ACCUM, DONE.
  - acc_lo[3:0].
  - acc_hi[2:0].
  - remaining[2:0].
- IDLE: in_ready=0, out_valid=0.
  - On start=1 with count≠0: clear acc_lo and acc_hi, set remaining=count, go to ACCUM.
  - On start=1 with count=0: clear acc_lo and acc_hi, go directly to DONE; the result is 0.
- ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready. On each accepted beat:
  - acc_lo <= add_s.
  - acc_hi <= acc_hi + add_cout (3-bit increment).
  - remaining <= remaining-1.
  - If remaining==1, go to DONE.
- No beat accepted: hold all registers.
- DONE: out_valid=1, in_ready=0. On out_ready=1, go to IDLE; acc registers hold their values.
- Arithmetic:
  - The 7-bit sum cannot overflow: 7×15=105 < 128.
  - acc_hi therefore never wraps in a legal run.
- add_a/add_b/add_cin are driven in every state. Only ACCUM acceptance uses add_s/add_cout.
- abort=1 in any state: go to IDLE next edge, clear remaining. No out_valid is produced.
  - abort has priority over beat acceptance, start, and out_ready in the same cycle.
- start in ACCUM or DONE is ignored; count is sampled only with an accepted start.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE.
  - acc_lo=0, acc_hi=0, remaining=0.
  - in_ready=0, out_valid=0, out_sum=0.
  - add_a=0, add_cin=0.
- Reset takes effect immediately, even mid-run; the partial sum is discarded.
- start in IDLE at edge k puts the block in ACCUM; in_ready=1 from cycle k+1.
- Each accepted operand updates the sum on the same edge; there is one beat per cycle maximum and no bubbles are required.
- The last operand accepted at edge m raises out_valid in cycle m+1. Latency for N back-to-back operands is N+1 cycles from start to out_valid.
- For count=0, out_valid is asserted in the cycle after start.
- out_valid and out_sum stay stable until out_ready is sampled high. The next start is accepted no earlier than the cycle after the result handshake.
- All outputs are registered, except add_b (= in_data) and in_ready/out_valid, which are state decodes.

## Test plan
- Reset mid-run:
  - Stimulus: assert rst_n=0 after 2 of 4 operands.
  - Required response: all outputs 0 immediately, state IDLE.
  - Follow-on: a new run of count=1, data 9 gives out_sum=9.
- Basic run with carry:
  - Stimulus: start, count=3, operands 5, 7, 9 back-to-back.
  - Required response: out_valid 4 cycles after start, out_sum=21 (acc_hi=1, acc_lo=5); with out_ready held high it returns to IDLE next cycle.
- Maximum sum with stalls:
  - Stimulus: count=7, all operands 15, with random in_valid gaps.
  - Required response: out_sum=105; no extra beats accepted after the 7th.
- Result backpressure:
  - Stimulus: out_ready held 0 for 5 cycles.
  - Required response: out_valid and out_sum=21 held constant; a start asserted during DONE is ignored.
- count=0:
  - Stimulus: start with count=0.
  - Required response: out_valid the next cycle, out_sum=0; in_ready never asserted.
- Abort with beat:
  - Stimulus: abort in ACCUM in the same cycle as a valid beat (count=4, after 2 beats of 8).
  - Required response: beat not accepted, IDLE next cycle, no out_valid.
  - Follow-on: a new run with count=2, data 1, 2 gives out_sum=3.
